// File: rtl/input_event_controller.sv
// Debounced 8-input event controller: shared sample prescaler, per-input stability counters,
// lowest-index arbiter and a 4-entry event FIFO. INPUT_EVENT_CONTROLLER_RELEASE_EN also queues release events.
module input_event_controller #(
   parameter int                        prescalerWidth = 8,
   parameter logic [prescalerWidth-1:0] prescalerMax   = 8'd255,
   parameter int                        thresholdWidth = 4,
   parameter logic [thresholdWidth-1:0] threshold      = 4'b1111
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] dataIn,
   output logic [7:0] levels,
   output logic       eventValid,
   output logic [3:0] eventCode,
   input  logic       eventAck,
   output logic       overflow,
   input  logic       overflowClear
);

   logic [7:0]                     sync_0;
   logic [7:0]                     sync_1;
   logic [prescalerWidth-1:0]      prescaler;
   logic [7:0][thresholdWidth-1:0] counter;
   logic [7:0]                     pending;
   logic [3:0][3:0]                fifo_mem;
   logic [1:0]                     rd_ptr;
   logic [1:0]                     wr_ptr;
   logic [2:0]                     count;

   logic                           tick;
   logic [7:0][thresholdWidth-1:0] counter_next;
   logic [7:0]                     levels_next;
   logic [7:0]                     set_mask;
   logic [7:0]                     grant_mask;
   logic [7:0]                     pending_next;
   logic [2:0]                     sel;
   logic                           found;
   logic                           pop;
   logic                           push;
   logic                           lost;
   logic [3:0]                     push_code;
   logic [2:0]                     count_next;
   logic [3:0]                     head_next;

   assign tick = (prescaler == prescalerMax);

   always_comb begin
      counter_next = counter;
      levels_next  = levels;
      set_mask     = '0;
      if (tick) begin
         for (int i = 0; i < 8; i++) begin
            if (sync_1[i] == levels[i]) begin
               counter_next[i] = '0;
            end else if (counter[i] == threshold - 1'b1) begin
               counter_next[i] = '0;
               levels_next[i]  = ~levels[i];
`ifdef INPUT_EVENT_CONTROLLER_RELEASE_EN
               set_mask[i]     = 1'b1;
`else
               set_mask[i]     = ~levels[i];
`endif
            end else begin
               counter_next[i] = counter[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (pending[i] && !found) begin
            sel   = i[2:0];
            found = 1'b1;
         end
      end
   end

   assign pop        = eventAck && eventValid;
   assign push       = found && ((count != 3'd4) || pop);
   assign grant_mask = push ? (8'b1 << sel) : 8'b0;
   // Only a change whose previous event is neither queued nor leaving this cycle is lost.
   assign lost         = |(set_mask & pending & ~grant_mask);
   assign pending_next = (pending & ~grant_mask) | set_mask;

`ifdef INPUT_EVENT_CONTROLLER_RELEASE_EN
   assign push_code = {levels[sel], sel};
`else
   assign push_code = {1'b1, sel};
`endif

   always_comb begin
      count_next = count;
      unique case ({push, pop})
         2'b10:   count_next = count + 3'd1;
         2'b01:   count_next = count - 3'd1;
         default: count_next = count;
      endcase
   end

   // eventCode always mirrors the head after this edge's push/pop.
   always_comb begin
      head_next = eventCode;
      if (pop) begin
         if (count >= 3'd2)
            head_next = fifo_mem[rd_ptr + 2'd1];
         else if (push)
            head_next = push_code;
      end else if ((count == 3'd0) && push) begin
         head_next = push_code;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_0     <= '0;
         sync_1     <= '0;
         prescaler  <= '0;
         counter    <= '0;
         levels     <= '0;
         pending    <= '0;
         fifo_mem   <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         eventValid <= 1'b0;
         eventCode  <= 4'h0;
         overflow   <= 1'b0;
      end else begin
         sync_0    <= dataIn;
         sync_1    <= sync_0;
         prescaler <= tick ? '0 : prescaler + 1'b1;
         counter   <= counter_next;
         levels    <= levels_next;
         pending   <= pending_next;
         if (push) begin
            fifo_mem[wr_ptr] <= push_code;
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         count      <= count_next;
         eventValid <= (count_next != 3'd0);
         eventCode  <= head_next;
         if (lost)
            overflow <= 1'b1;
         else if (overflowClear)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_input_event_controller.sv
// Self-checking bench for input_event_controller (prescalerMax=3, threshold=3).
// Expectations follow INPUT_EVENT_CONTROLLER_RELEASE_EN when it is defined for the build.
module tb_input_event_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] dataIn = 8'h00;
   logic [7:0] levels;
   logic       eventValid;
   logic [3:0] eventCode;
   logic       eventAck = 1'b0;
   logic       overflow;
   logic       overflowClear = 1'b0;

   int checks = 0;
   int errors = 0;

   input_event_controller #(
      .prescalerWidth(8),
      .prescalerMax  (8'd3),
      .thresholdWidth(4),
      .threshold     (4'd3)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .dataIn       (dataIn),
      .levels       (levels),
      .eventValid   (eventValid),
      .eventCode    (eventCode),
      .eventAck     (eventAck),
      .overflow     (overflow),
      .overflowClear(overflowClear)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] data;
      logic       ack;
      logic       clr;
      int         wait_n;
      logic [7:0] exp_levels;
      logic       exp_valid;
      logic [3:0] exp_code;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset(input logic [7:0] d);
      @(negedge clock);
      reset  = 1'b1;
      dataIn = d;
      eventAck = 1'b0;
      overflowClear = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_levels(input string name, input logic [7:0] target);
      int n;
      n = 0;
      while (levels !== target && n < 18) begin
         @(negedge clock);
         n++;
      end
      check(name, levels, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic bad;
      logic [3:0] exp_code;
      logic exp_ovf;

      vecs[0] = '{8'h00, 1'b0, 1'b0, 30, 8'h00, 1'b0, 4'h0, 1'b0};
      vecs[1] = '{8'h04, 1'b0, 1'b0, 30, 8'h04, 1'b1, 4'hA, 1'b0};
      vecs[2] = '{8'h04, 1'b1, 1'b0, 4,  8'h04, 1'b0, 4'h0, 1'b0};
`ifdef INPUT_EVENT_CONTROLLER_RELEASE_EN
      vecs[3] = '{8'h00, 1'b0, 1'b0, 30, 8'h00, 1'b1, 4'h2, 1'b0};
`else
      vecs[3] = '{8'h00, 1'b0, 1'b0, 30, 8'h00, 1'b0, 4'h0, 1'b0};
`endif
      vecs[4] = '{8'h00, 1'b1, 1'b0, 4,  8'h00, 1'b0, 4'h0, 1'b0};
      vecs[5] = '{8'h81, 1'b0, 1'b0, 30, 8'h81, 1'b1, 4'h8, 1'b0};
      vecs[6] = '{8'h81, 1'b1, 1'b0, 3,  8'h81, 1'b1, 4'hF, 1'b0};
      vecs[7] = '{8'h81, 1'b1, 1'b0, 3,  8'h81, 1'b0, 4'h0, 1'b0};
      vecs[8] = '{8'h81, 1'b0, 1'b1, 3,  8'h81, 1'b0, 4'h0, 1'b0};
`ifdef INPUT_EVENT_CONTROLLER_RELEASE_EN
      vecs[9] = '{8'h01, 1'b0, 1'b0, 30, 8'h01, 1'b1, 4'h7, 1'b0};
`else
      vecs[9] = '{8'h01, 1'b0, 1'b0, 30, 8'h01, 1'b0, 4'h0, 1'b0};
`endif

      // Reset state
      @(negedge clock);
      @(negedge clock);
      check("reset_levels", levels, 8'h00);
      check("reset_valid", {7'd0, eventValid}, 8'h00);
      check("reset_code", {4'd0, eventCode}, 8'h00);
      check("reset_ovf", {7'd0, overflow}, 8'h00);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         dataIn        = vecs[i].data;
         eventAck      = vecs[i].ack;
         overflowClear = vecs[i].clr;
         @(negedge clock);
         eventAck      = 1'b0;
         overflowClear = 1'b0;
         repeat (vecs[i].wait_n) @(negedge clock);
         check($sformatf("vec%0d_levels", i), levels, vecs[i].exp_levels);
         check($sformatf("vec%0d_valid", i), {7'd0, eventValid}, {7'd0, vecs[i].exp_valid});
         if (vecs[i].exp_valid)
            check($sformatf("vec%0d_code", i), {4'd0, eventCode}, {4'd0, vecs[i].exp_code});
         check($sformatf("vec%0d_ovf", i), {7'd0, overflow}, {7'd0, vecs[i].exp_ovf});
      end

      // Debounce latency and valid one cycle after levels
      do_reset(8'h04);
      wait_levels("lat_levels", 8'h04);
      check("lat_valid_before", {7'd0, eventValid}, 8'h00);
      @(negedge clock);
      check("lat_valid_after", {7'd0, eventValid}, 8'h01);
      check("lat_code", {4'd0, eventCode}, 8'h0A);
      eventAck = 1'b1;
      @(negedge clock);
      eventAck = 1'b0;
      check("lat_ack_valid", {7'd0, eventValid}, 8'h00);

      // Bounce rejection
      do_reset(8'h00);
      bad = 1'b0;
      for (int k = 0; k < 12; k++) begin
         dataIn = (k % 2 == 0) ? 8'h01 : 8'h00;
         repeat (5) begin
            @(negedge clock);
            if (levels[0] !== 1'b0 || eventValid !== 1'b0) bad = 1'b1;
         end
      end
      check("bounce_stable", {7'd0, bad}, 8'h00);
      dataIn = 8'h01;
      repeat (30) @(negedge clock);
      check("bounce_valid", {7'd0, eventValid}, 8'h01);
      check("bounce_code", {4'd0, eventCode}, 8'h08);
      eventAck = 1'b1;
      @(negedge clock);
      eventAck = 1'b0;
      repeat (30) @(negedge clock);
      check("bounce_single", {7'd0, eventValid}, 8'h00);

      // FIFO full: 4 queued, 2 held pending
      do_reset(8'h3F);
      repeat (30) @(negedge clock);
      check("full_valid", {7'd0, eventValid}, 8'h01);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("full_pop%0d", k), {4'd0, eventCode}, {4'd0, 1'b1, k[2:0]});
         eventAck = 1'b1;
         @(negedge clock);
      end
      eventAck = 1'b0;
      check("full_empty", {7'd0, eventValid}, 8'h00);
      check("full_ovf", {7'd0, overflow}, 8'h00);

      // Press then release of bit 6 while the FIFO is full
`ifdef INPUT_EVENT_CONTROLLER_RELEASE_EN
      exp_code = 4'h6;
      exp_ovf  = 1'b1;
`else
      exp_code = 4'hE;
      exp_ovf  = 1'b0;
`endif
      do_reset(8'h0F);
      repeat (30) @(negedge clock);
      dataIn = 8'h4F;
      repeat (30) @(negedge clock);
      dataIn = 8'h0F;
      repeat (30) @(negedge clock);
      check("ovf_flag", {7'd0, overflow}, {7'd0, exp_ovf});
      eventAck = 1'b1;
      repeat (4) @(negedge clock);
      eventAck = 1'b0;
      check("ovf_valid", {7'd0, eventValid}, 8'h01);
      check("ovf_code", {4'd0, eventCode}, {4'd0, exp_code});
      check("ovf_sticky", {7'd0, overflow}, {7'd0, exp_ovf});
      overflowClear = 1'b1;
      @(negedge clock);
      overflowClear = 1'b0;
      check("ovf_cleared", {7'd0, overflow}, 8'h00);

      // Reset mid-operation, then inputs held high through reset
      do_reset(8'h07);
      repeat (30) @(negedge clock);
      check("mid_valid_before", {7'd0, eventValid}, 8'h01);
      reset = 1'b1;
      @(negedge clock);
      check("mid_valid", {7'd0, eventValid}, 8'h00);
      check("mid_levels", levels, 8'h00);
      check("mid_ovf", {7'd0, overflow}, 8'h00);
      reset = 1'b0;
      wait_levels("held_levels", 8'h07);
      @(negedge clock);
      check("held_valid", {7'd0, eventValid}, 8'h01);
      check("held_code", {4'd0, eventCode}, 8'h08);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
